// File: rtl/mem_arbiter_ctrl_if.sv
// rtl/mem_arbiter_ctrl_if.sv - requester handshake bundle for the SRAM arbiter
interface mem_arbiter_ctrl_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_ack;

    logic        ldr_req;
    logic        ldr_we;
    logic [15:0] ldr_addr;
    logic [15:0] ldr_wdata;
    logic [15:0] ldr_rdata;
    logic        ldr_ack;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ack,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  ldr_rdata, ldr_ack
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ack,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output ldr_rdata, ldr_ack
    );
endinterface

// File: rtl/mem_arbiter_ctrl.sv
// rtl/mem_arbiter_ctrl.sv - two-port SRAM arbiter with fixed wait states and switch/hex I/O decode
module mem_arbiter_ctrl #(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic               Clk,
    input  logic               Reset,
    mem_arbiter_ctrl_if.slave  bus,
    input  logic [15:0]        S,
    output logic [15:0]        hex_out,
    output logic               CE,
    output logic               UB,
    output logic               LB,
    output logic               OE,
    output logic               WE,
    output logic [19:0]        ADDR,
    inout  wire  [15:0]        Data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        grant_cpu;
    logic        last_grant_ldr;
    logic        we_q;
    logic [15:0] wdata_q;
    logic        data_oe;

    logic        any_req;
    logic        pick_cpu;
    logic        sel_we;
    logic [15:0] sel_addr;
    logic [15:0] sel_wdata;

    // Alternating priority on ties: the port that did not win last time goes first.
    always_comb begin
        any_req   = bus.cpu_req | bus.ldr_req;
        pick_cpu  = bus.cpu_req & (~bus.ldr_req | last_grant_ldr);
        sel_we    = pick_cpu ? bus.cpu_we    : bus.ldr_we;
        sel_addr  = pick_cpu ? bus.cpu_addr  : bus.ldr_addr;
        sel_wdata = pick_cpu ? bus.cpu_wdata : bus.ldr_wdata;
    end

    assign Data = data_oe ? wdata_q : 16'hzzzz;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            grant_cpu      <= 1'b0;
            last_grant_ldr <= 1'b1;
            we_q           <= 1'b0;
            wdata_q        <= 16'h0000;
            data_oe        <= 1'b0;
            CE             <= 1'b1;
            UB             <= 1'b1;
            LB             <= 1'b1;
            OE             <= 1'b1;
            WE             <= 1'b1;
            ADDR           <= 20'h00000;
            hex_out        <= 16'h0000;
            bus.cpu_rdata  <= 16'h0000;
            bus.ldr_rdata  <= 16'h0000;
            bus.cpu_ack    <= 1'b0;
            bus.ldr_ack    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.cpu_ack <= 1'b0;
                    bus.ldr_ack <= 1'b0;
                    if (any_req) begin
                        grant_cpu      <= pick_cpu;
                        last_grant_ldr <= ~pick_cpu;
                        we_q           <= sel_we;
                        wdata_q        <= sel_wdata;
                        ADDR           <= {4'h0, sel_addr};
                        if (sel_addr == IO_ADDR) begin
                            // I/O hit completes without touching the SRAM pins.
                            if (sel_we) begin
                                hex_out <= sel_wdata;
                            end else if (pick_cpu) begin
                                bus.cpu_rdata <= S;
                            end else begin
                                bus.ldr_rdata <= S;
                            end
                            bus.cpu_ack <= pick_cpu;
                            bus.ldr_ack <= ~pick_cpu;
                            state       <= DONE;
                        end else begin
                            cnt     <= CNT_INIT;
                            CE      <= 1'b0;
                            UB      <= 1'b0;
                            LB      <= 1'b0;
                            OE      <= sel_we;
                            WE      <= ~sel_we;
                            data_oe <= sel_we;
                            state   <= ACCESS;
                        end
                    end
                end

                ACCESS: begin
                    if (cnt == 4'd0) begin
                        CE      <= 1'b1;
                        UB      <= 1'b1;
                        LB      <= 1'b1;
                        OE      <= 1'b1;
                        WE      <= 1'b1;
                        data_oe <= 1'b0;
                        // Read data is taken on the last edge the SRAM is still enabled.
                        if (!we_q) begin
                            if (grant_cpu) begin
                                bus.cpu_rdata <= Data;
                            end else begin
                                bus.ldr_rdata <= Data;
                            end
                        end
                        bus.cpu_ack <= grant_cpu;
                        bus.ldr_ack <= ~grant_cpu;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                DONE: begin
                    bus.cpu_ack <= 1'b0;
                    bus.ldr_ack <= 1'b0;
                    state       <= IDLE;
                end

                default: begin
                    CE          <= 1'b1;
                    UB          <= 1'b1;
                    LB          <= 1'b1;
                    OE          <= 1'b1;
                    WE          <= 1'b1;
                    data_oe     <= 1'b0;
                    bus.cpu_ack <= 1'b0;
                    bus.ldr_ack <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
